// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch initiator for a registered-read instruction memory
// Optional feature macro: FETCH_MISALIGN_EN (flags fetches reached through a misaligned redirect).
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_inst,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_misalign
);

    logic [31:0] r_fetch_pc;
    logic [31:0] r_rsp_pc;
    logic        r_rsp_valid;
    logic        w_hold;

    // A stall with nothing on display has nothing to protect, so it is ignored.
    assign w_hold = stall & r_rsp_valid;

    always_comb begin
        imem_pc = r_fetch_pc;
        if (redirect) begin
            imem_pc = {redirect_pc[31:2], 2'b00};
        end else if (w_hold) begin
            imem_pc = r_rsp_pc;
        end
    end

    // Replaying rsp_pc during hold makes this uniform update leave all state unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc  <= RESET_PC;
            r_rsp_pc    <= 32'h0000_0000;
            r_rsp_valid <= 1'b0;
        end else begin
            r_fetch_pc  <= imem_pc + 32'd4;
            r_rsp_pc    <= imem_pc;
            r_rsp_valid <= 1'b1;
        end
    end

    assign if_pc    = r_rsp_pc;
    assign if_inst  = imem_inst;
    assign if_valid = r_rsp_valid & ~redirect;

`ifdef FETCH_MISALIGN_EN
    logic r_misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else if (redirect || !w_hold) begin
            r_misalign <= redirect & (|redirect_pc[1:0]);
        end
    end

    assign if_misalign = r_misalign & if_valid;
`else
    logic w_unused_pc_lsb;

    assign w_unused_pc_lsb = ^redirect_pc[1:0];
    assign if_misalign     = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized checks of fetch_unit against an instruction-stream model
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_pc;
    logic [31:0] imem_inst;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_misalign;

    int checks = 0;
    int errors = 0;

    // Model of what decode should see: the pc on display, whether anything is
    // live yet, and whether that pc was reached by a misaligned redirect.
    logic [31:0] m_pc;
    logic        m_live;
    logic        m_mis;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_pc     (imem_pc),
        .imem_inst   (imem_inst),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_inst     (if_inst),
        .if_misalign (if_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return (pc >> 2) + 32'd1;
    endfunction

    // Registered-read memory: word index i holds i+1.
    always @(posedge clk) imem_inst <= inst_of(imem_pc);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_misalign(input logic valid_now);
`ifdef FETCH_MISALIGN_EN
        chk("if_misalign", {31'b0, if_misalign}, {31'b0, m_mis & valid_now});
`else
        chk("if_misalign", {31'b0, if_misalign}, {31'b0, 1'b0 & valid_now});
`endif
    endtask

    task automatic step(input logic s, input logic r, input logic [31:0] rp);
        logic [31:0] e_addr;
        logic        e_valid;
        @(negedge clk);
        stall = s;
        redirect = r;
        redirect_pc = rp;
        #1;
        if (r)                 e_addr = {rp[31:2], 2'b00};
        else if (s && m_live)  e_addr = m_pc;
        else if (m_live)       e_addr = m_pc + 32'd4;
        else                   e_addr = RESET_PC;
        e_valid = m_live & ~r;
        chk("imem_pc", imem_pc, e_addr);
        chk("if_valid", {31'b0, if_valid}, {31'b0, e_valid});
        chk("if_pc", if_pc, m_pc);
        if (m_live) chk("if_inst", if_inst, inst_of(m_pc));
        check_misalign(e_valid);
        @(posedge clk);
        if (r)                 m_mis = |rp[1:0];
        else if (!(s && m_live)) m_mis = 1'b0;
        m_pc   = e_addr;
        m_live = 1'b1;
    endtask

    task automatic check_reset_state();
        chk("rst_imem_pc", imem_pc, RESET_PC);
        chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_misalign", {31'b0, if_misalign}, 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        redirect = 1'b0;
        #1;
        m_pc = 32'd0;
        m_live = 1'b0;
        m_mis = 1'b0;
        check_reset_state();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        stall = 1'b0;
    endtask

    initial begin
        logic s, r;
        logic [31:0] rp;
        rst_n = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'd0;
        m_pc = 32'd0;
        m_live = 1'b0;
        m_mis = 1'b0;
        #1;
        check_reset_state();
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Sequential fetch from reset
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        // Stall for 3 cycles while pc 8 is shown
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        // Redirect to 0x40
        step(0, 1, 32'h40);
        step(0, 0, 0);
        chk("redir_if_inst", if_inst, 32'd17);
        step(0, 0, 0);
        // Redirect and stall together
        step(1, 1, 32'h80);
        step(0, 0, 0);
        // Misaligned redirect
        step(0, 1, 32'h42);
        step(0, 0, 0);
        step(0, 0, 0);
        // Misaligned redirect followed by a stall on the flagged pair
        step(0, 1, 32'h103);
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        // Address wrap at the top of the space
        step(0, 1, 32'hFFFF_FFF8);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        // Reset in the middle of a stall at pc 0x20
        step(0, 1, 32'h20);
        step(1, 0, 0);
        step(1, 0, 0);
        stall = 1'b1;
        pulse_reset();
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        // Stall with nothing live is ignored
        pulse_reset();
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            s = ($urandom_range(0, 9) < 3);
            r = ($urandom_range(0, 9) < 2);
            if ($urandom_range(0, 9) == 0) rp = 32'hFFFF_FFF0 | $urandom_range(0, 15);
            else                           rp = $urandom & 32'h0000_0FFF;
            step(s, r, rp);
            if ($urandom_range(0, 99) == 0) begin
                stall = s;
                pulse_reset();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
